// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: buffers one fetched instruction pair and issues it to two lanes,
// dual-issuing when the pair is hazard-free and splitting it into two in-order issues otherwise.
module dual_issue_scheduler #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_b_valid,
  input  logic [31:0]      in_a_instr,
  input  logic [31:0]      in_b_instr,
  input  logic [31:0]      in_a_pc,
  input  logic [31:0]      in_b_pc,
  input  logic [REG_W-1:0] in_a_rs,
  input  logic [REG_W-1:0] in_a_rt,
  input  logic [REG_W-1:0] in_a_wreg,
  input  logic [REG_W-1:0] in_b_rs,
  input  logic [REG_W-1:0] in_b_rt,
  input  logic [REG_W-1:0] in_b_wreg,
  input  logic             in_a_regwrite,
  input  logic             in_a_lw,
  input  logic             in_a_sw,
  input  logic             in_b_regwrite,
  input  logic             in_b_lw,
  input  logic             in_b_sw,
  input  logic             stall,
  input  logic             flush,
  output logic             lane0_valid,
  output logic [31:0]      lane0_instr,
  output logic [31:0]      lane0_pc,
  output logic             lane1_valid,
  output logic [31:0]      lane1_instr,
  output logic [31:0]      lane1_pc,
  output logic [CNT_W-1:0] dual_cnt,
  output logic [CNT_W-1:0] split_cnt
);

  typedef enum logic [1:0] {IDLE, FULL, HALF} state_t;

  state_t             state;
  logic [31:0]        a_instr, a_pc, b_instr, b_pc;
  logic [REG_W-1:0]   a_wreg, b_rs, b_rt, b_wreg;
  logic               a_regwrite, a_mem, b_valid, b_regwrite, b_mem;

  logic               conflict, mem_hit, raw_hit, waw_hit, accept, dual_inc;

  // Slot A's source specifiers never matter: A is always the older instruction.
  logic unused_fields;
  assign unused_fields = ^{in_a_rs, in_a_rt};

  always_comb begin
    mem_hit  = a_mem && b_mem;
    raw_hit  = a_regwrite && (a_wreg != '0) && ((a_wreg == b_rs) || (a_wreg == b_rt));
    waw_hit  = a_regwrite && b_regwrite && (a_wreg == b_wreg) && (a_wreg != '0);
    conflict = b_valid && (mem_hit || raw_hit || waw_hit);
  end

  always_comb begin
    lane0_valid = 1'b0;
    lane0_instr = '0;
    lane0_pc    = '0;
    lane1_valid = 1'b0;
    lane1_instr = '0;
    lane1_pc    = '0;
    in_ready    = 1'b0;
    case (state)
      IDLE: in_ready = !flush;
      FULL: begin
        lane0_valid = 1'b1;
        lane0_instr = a_instr;
        lane0_pc    = a_pc;
        if (b_valid && !conflict) begin
          lane1_valid = 1'b1;
          lane1_instr = b_instr;
          lane1_pc    = b_pc;
        end
        in_ready = !stall && !conflict && !flush;
      end
      HALF: begin
        lane0_valid = 1'b1;
        lane0_instr = b_instr;
        lane0_pc    = b_pc;
        in_ready    = !stall && !flush;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign dual_inc = lane0_valid && lane1_valid && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      a_instr    <= '0;
      a_pc       <= '0;
      a_wreg     <= '0;
      a_regwrite <= 1'b0;
      a_mem      <= 1'b0;
      b_valid    <= 1'b0;
      b_instr    <= '0;
      b_pc       <= '0;
      b_rs       <= '0;
      b_rt       <= '0;
      b_wreg     <= '0;
      b_regwrite <= 1'b0;
      b_mem      <= 1'b0;
      dual_cnt   <= '0;
      split_cnt  <= '0;
    end else begin
      if (dual_inc && (dual_cnt != '1))
        dual_cnt <= dual_cnt + CNT_W'(1);

      if (flush) begin
        state <= IDLE;
      end else if (accept) begin
        state      <= FULL;
        a_instr    <= in_a_instr;
        a_pc       <= in_a_pc;
        a_wreg     <= in_a_wreg;
        a_regwrite <= in_a_regwrite;
        a_mem      <= in_a_lw || in_a_sw;
        b_valid    <= in_b_valid;
        b_instr    <= in_b_instr;
        b_pc       <= in_b_pc;
        b_rs       <= in_b_rs;
        b_rt       <= in_b_rt;
        b_wreg     <= in_b_wreg;
        b_regwrite <= in_b_regwrite;
        b_mem      <= in_b_lw || in_b_sw;
      end else begin
        case (state)
          FULL: if (!stall) begin
            // On a split, the B buffer itself serves as the leftover register.
            if (conflict) begin
              state <= HALF;
              if (split_cnt != '1)
                split_cnt <= split_cnt + CNT_W'(1);
            end else begin
              state <= IDLE;
            end
          end
          HALF: if (!stall) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler: each accepted packet pushes its expected
// lane issues, and the monitor pops and compares whenever lane0 issues (stall low).
module tb_dual_issue_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, in_b_valid, stall, flush;
  logic [31:0] in_a_instr, in_b_instr, in_a_pc, in_b_pc;
  logic [4:0]  in_a_rs, in_a_rt, in_a_wreg, in_b_rs, in_b_rt, in_b_wreg;
  logic        in_a_regwrite, in_a_lw, in_a_sw, in_b_regwrite, in_b_lw, in_b_sw;
  logic        lane0_valid, lane1_valid;
  logic [31:0] lane0_instr, lane0_pc, lane1_instr, lane1_pc;
  logic [15:0] dual_cnt, split_cnt;

  dual_issue_scheduler #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_b_valid(in_b_valid), .in_a_instr(in_a_instr), .in_b_instr(in_b_instr),
    .in_a_pc(in_a_pc), .in_b_pc(in_b_pc),
    .in_a_rs(in_a_rs), .in_a_rt(in_a_rt), .in_a_wreg(in_a_wreg),
    .in_b_rs(in_b_rs), .in_b_rt(in_b_rt), .in_b_wreg(in_b_wreg),
    .in_a_regwrite(in_a_regwrite), .in_a_lw(in_a_lw), .in_a_sw(in_a_sw),
    .in_b_regwrite(in_b_regwrite), .in_b_lw(in_b_lw), .in_b_sw(in_b_sw),
    .stall(stall), .flush(flush),
    .lane0_valid(lane0_valid), .lane0_instr(lane0_instr), .lane0_pc(lane0_pc),
    .lane1_valid(lane1_valid), .lane1_instr(lane1_instr), .lane1_pc(lane1_pc),
    .dual_cnt(dual_cnt), .split_cnt(split_cnt)
  );

  typedef struct {
    logic [31:0] ai, api, bi, bpi;
    logic        bv;
    logic [4:0]  aw, brs, brt, bw;
    logic        arw, alw, asw, brw, blw, bsw;
  } pkt_t;

  typedef struct {
    logic [31:0] l0i, l0pc;
    logic        l1v;
    logic [31:0] l1i, l1pc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_dual = 0;
  int   exp_split = 0;
  bit   mon_en = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] pc, input logic [4:0] aw,
                              input logic arw, input logic alw, input logic asw,
                              input logic bv, input logic [4:0] brs, input logic [4:0] brt,
                              input logic [4:0] bw, input logic brw, input logic blw,
                              input logic bsw);
    pkt_t p;
    p.api = pc;
    p.bpi = pc + 32'd4;
    p.ai  = {6'h00, 5'd1, 5'd2, aw, 11'h020} ^ pc;
    p.bi  = {6'h00, brs, brt, bw, 11'h022} ^ pc;
    p.bv  = bv;
    p.aw  = aw;  p.arw = arw; p.alw = alw; p.asw = asw;
    p.brs = brs; p.brt = brt; p.bw = bw; p.brw = brw; p.blw = blw; p.bsw = bsw;
    return p;
  endfunction

  function automatic bit model_conflict(input pkt_t p);
    bit mem, raw, waw;
    mem = (p.alw | p.asw) & (p.blw | p.bsw);
    raw = p.arw && p.aw != 5'd0 && (p.aw == p.brs || p.aw == p.brt);
    waw = p.arw && p.brw && p.aw == p.bw && p.aw != 5'd0;
    return p.bv && (mem || raw || waw);
  endfunction

  task automatic drive_pkt(input pkt_t p);
    in_a_instr = p.ai;  in_a_pc = p.api;  in_b_instr = p.bi;  in_b_pc = p.bpi;
    in_b_valid = p.bv;
    in_a_rs = 5'd1; in_a_rt = 5'd2; in_a_wreg = p.aw;
    in_b_rs = p.brs; in_b_rt = p.brt; in_b_wreg = p.bw;
    in_a_regwrite = p.arw; in_a_lw = p.alw; in_a_sw = p.asw;
    in_b_regwrite = p.brw; in_b_lw = p.blw; in_b_sw = p.bsw;
  endtask

  task automatic push_pkt(input pkt_t p);
    if (p.bv && !model_conflict(p)) begin
      q.push_back('{l0i: p.ai, l0pc: p.api, l1v: 1'b1, l1i: p.bi, l1pc: p.bpi});
      exp_dual++;
    end else begin
      q.push_back('{l0i: p.ai, l0pc: p.api, l1v: 1'b0, l1i: 32'd0, l1pc: 32'd0});
      if (p.bv) begin
        q.push_back('{l0i: p.bi, l0pc: p.bpi, l1v: 1'b0, l1i: 32'd0, l1pc: 32'd0});
        exp_split++;
      end
    end
  endtask

  // Offer a packet until accepted (bounded); returns just after the capturing edge.
  task automatic send(input pkt_t p);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    drive_pkt(p);
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("send_accept", ok, 1);
    if (ok) push_pkt(p);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !lane0_valid) break;
    end
    check("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset && lane0_valid && !stall) begin
      if (q.size() == 0) begin
        check("unexpected_issue", q.size(), 1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("lane0_instr", lane0_instr, e.l0i);
        check("lane0_pc", lane0_pc, e.l0pc);
        check("lane1_valid", lane1_valid, e.l1v);
        if (e.l1v) begin
          check("lane1_instr", lane1_instr, e.l1i);
          check("lane1_pc", lane1_pc, e.l1pc);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p, p2;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    drive_pkt(mk(32'd0, 5'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0));
    #12;
    check("rst_lane0_valid", lane0_valid, 0);
    check("rst_lane1_valid", lane1_valid, 0);
    check("rst_dual", dual_cnt, 0);
    check("rst_split", split_cnt, 0);
    @(negedge clk); reset = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);

    // Independent pair: add $3,$1,$2 / sub $6,$4,$5
    send(mk(32'h100, 5'd3, 1, 0, 0, 1, 5'd4, 5'd5, 5'd6, 1, 0, 0));
    drain();
    check("indep_dual", dual_cnt, 16'(exp_dual));
    check("indep_split", split_cnt, 16'(exp_split));

    // RAW pair: A writes $8, B reads $8
    send(mk(32'h200, 5'd8, 1, 0, 0, 1, 5'd8, 5'd5, 5'd7, 1, 0, 0));
    @(negedge clk);
    check("raw_lane1_valid", lane1_valid, 0);
    check("raw_in_ready", in_ready, 0);
    drain();
    check("raw_split", split_cnt, 16'(exp_split));

    // Memory pair, WAW pair, $0 pair, single-instruction packet
    send(mk(32'h300, 5'd10, 1, 1, 0, 1, 5'd11, 5'd12, 5'd0, 0, 0, 1));
    drain();
    send(mk(32'h400, 5'd9, 1, 0, 0, 1, 5'd13, 5'd14, 5'd9, 1, 0, 0));
    drain();
    check("memwaw_split", split_cnt, 16'(exp_split));
    send(mk(32'h500, 5'd0, 1, 0, 0, 1, 5'd0, 5'd0, 5'd15, 1, 0, 0));
    drain();
    send(mk(32'h600, 5'd16, 1, 0, 0, 0, 5'd16, 5'd16, 5'd16, 1, 1, 1));
    drain();
    check("zero_dual", dual_cnt, 16'(exp_dual));
    check("zero_split", split_cnt, 16'(exp_split));

    // Stall held 3 cycles in FULL-conflict then in HALF
    p = mk(32'h700, 5'd20, 1, 0, 0, 1, 5'd1, 5'd20, 5'd21, 1, 0, 0);
    stall = 1'b1;
    send(p);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stallA_lane0", lane0_instr, p.ai);
      check("stallA_lane1_valid", lane1_valid, 0);
      check("stallA_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 stall = 1'b0;
    @(posedge clk); #1 stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stallB_lane0", lane0_instr, p.bi);
      check("stallB_lane0_valid", lane0_valid, 1);
      check("stallB_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 stall = 1'b0;
    drain();
    check("stall_split", split_cnt, 16'(exp_split));

    // Flush in HALF with a packet offered
    p  = mk(32'h800, 5'd22, 1, 0, 0, 1, 5'd22, 5'd2, 5'd23, 1, 0, 0);
    p2 = mk(32'h900, 5'd24, 1, 0, 0, 1, 5'd4, 5'd5, 5'd25, 1, 0, 0);
    send(p);
    @(posedge clk); #1;
    drive_pkt(p2);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    check("flush_lane0_shown", lane0_instr, p.bi);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_lane0_valid", lane0_valid, 0);
    check("flush_lane1_valid", lane1_valid, 0);
    check("flush_dual", dual_cnt, 16'(exp_dual));
    check("flush_split", split_cnt, 16'(exp_split));
    check("flush_queue", q.size(), 0);

    // Asynchronous reset while a pair is held in FULL
    stall = 1'b1;
    send(mk(32'hA00, 5'd3, 1, 0, 0, 1, 5'd4, 5'd5, 5'd6, 1, 0, 0));
    @(negedge clk);
    check("pre_rst_lane1_valid", lane1_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_lane0_valid", lane0_valid, 0);
    check("arst_lane1_valid", lane1_valid, 0);
    check("arst_lane0_instr", lane0_instr, 0);
    check("arst_dual", dual_cnt, 0);
    check("arst_split", split_cnt, 0);
    q.delete();
    exp_dual = 0;
    exp_split = 0;
    stall = 1'b0;
    #1 reset = 1'b0;
    #1 check("arst_in_ready", in_ready, 1);

    // Saturation: stream independent pairs back to back
    mon_en = 1'b0;
    @(posedge clk); #1;
    drive_pkt(mk(32'hB00, 5'd3, 1, 0, 0, 1, 5'd4, 5'd5, 5'd6, 1, 0, 0));
    in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sat_dual", dual_cnt, 16'hFFFF);
    check("sat_split", split_cnt, 16'(exp_split));
    check("sat_idle", lane0_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
